// File: rtl/bank_wl_sequencer_if.sv
// Command port between the bank controller and the wordline sequencer.
// The controller drives the master side; the sequencer is the slave.
interface bank_wl_sequencer_if #(
    parameter int ADDR_W = 2,
    parameter int CNT_W  = ADDR_W + 1
);
    localparam int ROWS = 1 << ADDR_W;

    logic              cs;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic              read_bar;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  mac_cnt;
    logic [ROWS-1:0]   data;
    logic [ROWS-1:0]   data_bar;

    modport master (
        output cs, cmd_valid, cmd_op, read_bar, addr, mac_cnt, data, data_bar,
        input  cmd_ready
    );

    modport slave (
        input  cs, cmd_valid, cmd_op, read_bar, addr, mac_cnt, data, data_bar,
        output cmd_ready
    );
endinterface

// File: rtl/bank_wl_sequencer.sv
// Clocked wordline sequencer for one CAM/MAC bank: write, MAC burst and CAM search pulses.
// Define WL_GAP_EN to insert one precharge cycle between consecutive MAC burst pulses.
module bank_wl_sequencer #(
    parameter int ADDR_W    = 2,
    parameter int PULSE_CYC = 2,
    parameter int CNT_W     = ADDR_W + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    bank_wl_sequencer_if.slave         cmd,
    output logic [(1 << ADDR_W)-1:0]   WL,
    output logic [(1 << ADDR_W)-1:0]   WLB,
    output logic [ADDR_W-1:0]          row_idx,
    output logic                       busy,
    output logic                       done
);
    // state | meaning
    // IDLE  | waiting for an accepted command, cmd_ready high
    // PULSE | wordlines driven, pulse counter running
    // GAP   | precharge cycle between MAC burst rows (WL_GAP_EN only)
    // DONE  | wordlines low, one-cycle done pulse
    localparam int ROWS = 1 << ADDR_W;
    localparam logic [3:0] PC_LAST = 4'(PULSE_CYC - 1);

`ifdef WL_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, DONE = 2'd2, GAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t            state_q;
    logic [3:0]        pcnt_q;
    logic [ADDR_W-1:0] row_q;
    logic [CNT_W-1:0]  left_q;
    logic [1:0]        op_q;
    logic              rbar_q;
    logic [ROWS-1:0]   wl_q, wlb_q;
    logic [ADDR_W-1:0] row_idx_q;
    logic              busy_q, done_q;
    logic              accept;
    logic [ADDR_W-1:0] row_nxt;

    // Concatenated {WL, WLB} for one pulse of the given operation
    function automatic logic [2*ROWS-1:0] wl_pattern(input logic [1:0] op, input logic rb,
                                                     input logic [ADDR_W-1:0] row,
                                                     input logic [ROWS-1:0] d,
                                                     input logic [ROWS-1:0] db);
        logic [ROWS-1:0] oh;
        oh      = '0;
        oh[row] = 1'b1;
        case (op)
            2'b00:   return {oh, oh};
            2'b01:   return rb ? {{ROWS{1'b0}}, oh} : {oh, {ROWS{1'b0}}};
            2'b10:   return {d, db};
            default: return '0;
        endcase
    endfunction

    // Zero rows means one; anything beyond the bank clamps to the bank size
    function automatic logic [CNT_W-1:0] eff_cnt(input logic [CNT_W-1:0] c);
        if (c == '0)              return CNT_W'(1);
        else if (c > CNT_W'(ROWS)) return CNT_W'(ROWS);
        else                       return c;
    endfunction

    assign cmd.cmd_ready = (state_q == IDLE);
    assign accept        = cmd.cmd_valid & cmd.cmd_ready & cmd.cs;
    assign row_nxt       = row_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            row_q     <= '0;
            left_q    <= '0;
            op_q      <= '0;
            rbar_q    <= 1'b0;
            wl_q      <= '0;
            wlb_q     <= '0;
            row_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        op_q   <= cmd.cmd_op;
                        rbar_q <= cmd.read_bar;
                        row_q  <= cmd.addr;
                        left_q <= eff_cnt(cmd.mac_cnt) - 1'b1;
                        pcnt_q <= '0;
                        busy_q <= 1'b1;
                        {wl_q, wlb_q} <= wl_pattern(cmd.cmd_op, cmd.read_bar, cmd.addr,
                                                    cmd.data, cmd.data_bar);
                        if (cmd.cmd_op == 2'b11) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= PULSE;
                            row_idx_q <= (cmd.cmd_op == 2'b10) ? '0 : cmd.addr;
                        end
                    end
                end
                PULSE: begin
                    if (!cmd.cs) begin
                        state_q   <= IDLE;
                        wl_q      <= '0;
                        wlb_q     <= '0;
                        row_idx_q <= '0;
                        busy_q    <= 1'b0;
                    end else if (pcnt_q != PC_LAST) begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end else if (op_q == 2'b01 && left_q != '0) begin
                        row_q     <= row_nxt;
                        row_idx_q <= row_nxt;
                        left_q    <= left_q - 1'b1;
                        pcnt_q    <= '0;
`ifdef WL_GAP_EN
                        state_q <= GAP;
                        wl_q    <= '0;
                        wlb_q   <= '0;
`else
                        {wl_q, wlb_q} <= wl_pattern(op_q, rbar_q, row_nxt, '0, '0);
`endif
                    end else begin
                        state_q   <= DONE;
                        wl_q      <= '0;
                        wlb_q     <= '0;
                        row_idx_q <= '0;
                        done_q    <= 1'b1;
                    end
                end
`ifdef WL_GAP_EN
                GAP: begin
                    if (!cmd.cs) begin
                        state_q   <= IDLE;
                        row_idx_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        state_q <= PULSE;
                        {wl_q, wlb_q} <= wl_pattern(op_q, rbar_q, row_q, '0, '0);
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    wl_q    <= '0;
                    wlb_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign WL      = wl_q;
    assign WLB     = wlb_q;
    assign row_idx = row_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_bank_wl_sequencer.sv
// Directed bench for bank_wl_sequencer (ADDR_W=2, PULSE_CYC=2); honours WL_GAP_EN when defined.
module tb_bank_wl_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] WL, WLB;
    logic [1:0] row_idx;
    logic       busy, done;
    int         n_chk = 0;
    int         n_err = 0;

    bank_wl_sequencer_if #(.ADDR_W(2)) bus ();

    bank_wl_sequencer #(.ADDR_W(2), .PULSE_CYC(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (bus),
        .WL      (WL),
        .WLB     (WLB),
        .row_idx (row_idx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one edge; on return the first post-accept cycle is visible
    task automatic issue(input logic [1:0] op, input logic rb, input logic [1:0] a,
                         input logic [2:0] cnt, input logic [3:0] d, input logic [3:0] db);
        bus.cs        = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.read_bar  = rb;
        bus.addr      = a;
        bus.mac_cnt   = cnt;
        bus.data      = d;
        bus.data_bar  = db;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_done_wl"}, {WL, WLB}, 0);
        check({tag, "_done_busy"}, busy, 1);
        step();
        check({tag, "_ready"}, bus.cmd_ready, 1);
        check({tag, "_done_clr"}, done, 0);
    endtask

    // Expected rows derived from the clamp rule: 0 -> 1 row, >4 -> 4 rows
    task automatic run_mac(input string tag, input logic [1:0] a, input logic [2:0] cnt,
                           input logic rb);
        int         n;
        logic [1:0] r;
        logic [3:0] oh;
        n = (cnt == 0) ? 1 : ((cnt > 4) ? 4 : int'(cnt));
        r = a;
        issue(2'b01, rb, a, cnt, 4'h0, 4'h0);
        for (int i = 0; i < n; i++) begin
            oh = 4'b0001 << r;
            for (int p = 0; p < 2; p++) begin
                check({tag, "_wl"}, WL, rb ? 4'h0 : oh);
                check({tag, "_wlb"}, WLB, rb ? oh : 4'h0);
                check({tag, "_row"}, row_idx, r);
                step();
            end
            r = r + 2'd1;
`ifdef WL_GAP_EN
            if (i < n - 1) begin
                check({tag, "_gap"}, {WL, WLB}, 0);
                check({tag, "_gap_row"}, row_idx, r);
                step();
            end
`endif
        end
        check_done(tag);
    endtask

`ifdef WL_GAP_EN
    localparam int NV = 8;
    localparam logic [3:0] MAC_WLB [NV] = '{4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2};
    localparam logic [1:0] MAC_ROW [NV] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
`else
    localparam int NV = 6;
    localparam logic [3:0] MAC_WLB [NV] = '{4'h8, 4'h8, 4'h1, 4'h1, 4'h2, 4'h2};
    localparam logic [1:0] MAC_ROW [NV] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
`endif

    initial begin
        bus.cs = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.read_bar = 1'b0;
        bus.addr = '0; bus.mac_cnt = '0; bus.data = '0; bus.data_bar = '0;
        step();
        step();
        check("rst_wl", {WL, WLB}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_row", row_idx, 0);
        rst_n = 1'b1;
        step();
        check("rst_ready", bus.cmd_ready, 1);

        // cs low blocks acceptance
        bus.cmd_valid = 1'b1; bus.cs = 1'b0; bus.cmd_op = 2'b00;
        step();
        bus.cmd_valid = 1'b0;
        check("nocs_busy", busy, 0);
        check("nocs_wl", WL, 0);

        // Write row 2
        issue(2'b00, 1'b0, 2'd2, 3'd0, 4'h0, 4'h0);
        for (int c = 1; c <= 2; c++) begin
            check("wr_wl", WL, 4'b0100);
            check("wr_wlb", WLB, 4'b0100);
            check("wr_row", row_idx, 2);
            check("wr_busy", busy, 1);
            check("wr_ready", bus.cmd_ready, 0);
            step();
        end
        check_done("wr");

        // MAC read_bar=1 addr=3 cnt=3, hand vectors
        issue(2'b01, 1'b1, 2'd3, 3'd3, 4'h0, 4'h0);
        for (int c = 0; c < NV; c++) begin
            check("mac3_wlb", WLB, MAC_WLB[c]);
            check("mac3_wl", WL, 0);
            check("mac3_row", row_idx, MAC_ROW[c]);
            step();
        end
        check_done("mac3");

        // CAM: key changed after accept must not leak through
        issue(2'b10, 1'b0, 2'd1, 3'd0, 4'b1010, 4'b0101);
        bus.data = 4'b0000; bus.data_bar = 4'b1111;
        for (int c = 1; c <= 2; c++) begin
            check("cam_wl", WL, 4'b1010);
            check("cam_wlb", WLB, 4'b0101);
            check("cam_row", row_idx, 0);
            step();
        end
        check_done("cam");

        run_mac("mac_c0", 2'd1, 3'd0, 1'b0);
        run_mac("mac_c7", 2'd0, 3'd7, 1'b0);
        run_mac("mac_c2", 2'd3, 3'd2, 1'b0);

        // Reserved op: straight to DONE, no wordlines
        issue(2'b11, 1'b0, 2'd2, 3'd0, 4'hf, 4'hf);
        check_done("op11");

        // Abort: cs dropped during cycle 2 of a 4-row burst
        issue(2'b01, 1'b0, 2'd0, 3'd4, 4'h0, 4'h0);
        check("ab_c1", WL, 4'b0001);
        step();
        check("ab_c2", WL, 4'b0001);
        bus.cs = 1'b0;
        step();
        check("ab_wl", {WL, WLB}, 0);
        check("ab_done", done, 0);
        check("ab_busy", busy, 0);
        check("ab_ready", bus.cmd_ready, 1);
        step();
        check("ab_done2", done, 0);
        check("ab_wl2", WL, 0);

        // Asynchronous reset mid-pulse
        issue(2'b00, 1'b0, 2'd1, 3'd0, 4'h0, 4'h0);
        check("rs_pre", WL, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_wl", {WL, WLB}, 0);
        check("rs_busy", busy, 0);
        check("rs_done", done, 0);
        step();
        rst_n = 1'b1;
        step();
        check("rs_ready", bus.cmd_ready, 1);
        check("rs_done2", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/bank_wl_sequencer.md
Name: bank_wl_sequencer

Overview:
- Parametrised, clocked wordline driver for one CAM/MAC SRAM bank; successor to the combinational 4-row decoder.
- Decodes a row address to 2**ADDR_W wordline pairs (WL/WLB) and drives timed pulses of programmable width.
- Supports three operations: write, MAC read and CAM search.
- Adds a multi-row MAC burst: consecutive rows pulsed in sequence with wrap-around. Sits between the bank controller's command port and the array wordline drivers.

Parameters:
- ADDR_W, 2, row address width; ROWS = 2**ADDR_W wordline pairs.
- PULSE_CYC, 2, wordline pulse width in clk cycles (legal range 1..15).
- CNT_W, ADDR_W+1, width of the MAC burst row-count field.

Ports:
- clk  input  1  bank clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  bank select; commands accepted only when high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high when sequencer can accept a command.
- cmd_op  input  2  00 write, 01 MAC, 10 CAM search, 11 reserved.
- read_bar  input  1  MAC polarity: 0 drives WL, 1 drives WLB.
- addr  input  ADDR_W  target row (write) or first row (MAC).
- mac_cnt  input  CNT_W  number of rows in MAC burst.
- data  input  ROWS  CAM search key, true rail.
- data_bar  input  ROWS  CAM search key, complement rail.
- WL  output  ROWS  registered wordlines, true side.
- WLB  output  ROWS  registered wordlines, bar side.
- row_idx  output  ADDR_W  row currently pulsed (MAC/write); 0 otherwise.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at completion.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; WL=0, WLB=0, row_idx=0, busy=0, done=0, cmd_ready=1 once reset is released. Reset mid-operation drops all wordlines immediately, with no done.
- cmd_ready = (state==IDLE). Accept = cmd_valid & cmd_ready & cs on a rising edge. All command fields are latched at accept and ignored afterwards.
- States: IDLE, PULSE, GAP (only with optional feature), DONE.
  - IDLE -> PULSE on accept (op 00/01/10).
  - IDLE -> DONE on accept of op 11; wordlines stay 0.
- PULSE: outputs held for exactly PULSE_CYC cycles, starting the cycle after accept. Pulse counter counts 0..PULSE_CYC-1.
  - Write: WL = WLB = one-hot(row).
  - MAC, read_bar=0: WL = one-hot(row), WLB=0.
  - MAC, read_bar=1: WLB = one-hot(row), WL=0.
  - CAM: WL = latched data, WLB = latched data_bar; row_idx=0.
- MAC burst:
  - Effective count = mac_cnt, except 0 is treated as 1 and values above ROWS clamp to ROWS.
  - Row advances to (row+1) mod ROWS after each pulse. Wrap from ROWS-1 to 0 is legal.
  - With the optional feature disabled, consecutive pulses are back-to-back with no idle cycle.
- End of last pulse -> DONE: WL=WLB=0, done=1 for one cycle, busy=1. Then -> IDLE. A new command can be accepted the cycle after DONE.
- cs low while busy: abort.
  - Next edge: WL=WLB=0, state -> IDLE, no done pulse.
  - cs is not sampled in DONE; done still fires.
- cmd_valid while busy: ignored (not queued); requester holds it until cmd_ready.
- Outputs are glitch-free (fully registered). Never more than one bit of WL set during write or MAC.

Optional Feature:
- Macro: WL_GAP_EN.
- Defined: adds state GAP. Between consecutive MAC burst pulses, one cycle with WL=WLB=0 (bitline precharge), row_idx already showing the next row. No GAP after the last pulse or for write/CAM. Burst length becomes N*PULSE_CYC + (N-1).
- Undefined: GAP state and logic absent; pulses back-to-back.

Test Plan (ADDR_W=2, PULSE_CYC=2, WL_GAP_EN undefined unless noted):
- Write, addr=2, accept at cycle 0 -> WL=WLB=4'b0100 in cycles 1-2; cycle 3 WL=WLB=0, done=1; cmd_ready=1 at cycle 4.
- MAC, read_bar=1, addr=3, mac_cnt=3 -> WLB=1000,1000,0001,0001,0010,0010 in cycles 1-6; WL=0 throughout; row_idx 3,0,1; done at cycle 7.
- Same MAC with WL_GAP_EN defined -> WLB=1000,1000,0000,0001,0001,0000,0010,0010; done at cycle 9.
- CAM, data=1010, data_bar=0101 -> WL=1010, WLB=0101 for cycles 1-2. New data changed at cycle 1 does not alter outputs.
- mac_cnt=0 -> single row pulse. mac_cnt=7 -> 4 rows then done. Op 11 -> no wordline activity, done at cycle 1.
- Abort and reset: cs dropped at cycle 2 of a 4-row MAC -> WL/WLB=0 at cycle 3, no done, cmd_ready=1. rst_n low mid-pulse -> outputs 0 asynchronously.
